// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard/flush scheduler for the five-stage pipeline.
// Each cycle it selects one of four actions: branch-mispredict flush,
// interrupt entry, halt, or load-use stall. It drives the PC and IF_ID write
// enables and the ID_EX flush controls.
//
// State tracked across cycles:
//   - run / in-service / halted
//   - a registered interrupt-pending bit
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   id_ra/id_rb(_used)         source registers of the instruction in ID
//   ex_desreg/memtoreg/regwrite destination and load info of the instruction in EX
//   ex_mispredict/halt/eret    control events resolved in EX
//   irq_req, int_en            level interrupt request, global enable
//   pc_en, if_id_en            PC / IF_ID write enables
//   bubble_rst, jump_rst       ID_EX bubble insert / IF_ID+ID_EX flush
//   interrupt                  one-cycle interrupt-entry pulse
//   in_service, halted         state flags
//   stall_cnt, flush_cnt       performance counters
//
// Optional: define HAZ_PERF_CNT_EN to build the saturating performance
// counters. When it is undefined, stall_cnt and flush_cnt are tied to 0.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ZERO_HAZ = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic [4:0]       ex_desreg,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic             ex_mispredict,
  input  logic             ex_halt,
  input  logic             ex_eret,
  input  logic             irq_req,
  input  logic             int_en,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             bubble_rst,
  output logic             jump_rst,
  output logic             interrupt,
  output logic             in_service,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, ISR, HALTED} st_t;

  st_t  st, st_nxt;
  logic irq_pend;
  logic load_use;

  assign load_use = ex_memtoreg & ex_regwrite &
                    ((id_ra_used & (id_ra == ex_desreg)) |
                     (id_rb_used & (id_rb == ex_desreg))) &
                    ((ZERO_HAZ != 0) | (ex_desreg != 5'd0));

  always_comb begin
    pc_en      = 1'b0;
    if_id_en   = 1'b0;
    bubble_rst = 1'b0;
    jump_rst   = 1'b0;
    interrupt  = 1'b0;
    st_nxt     = st;
    if (!rst) begin
      case (st)
        RUN, ISR: begin
          if (ex_halt) begin
            jump_rst = 1'b1;
            st_nxt   = HALTED;
          end else if (ex_mispredict) begin
            jump_rst = 1'b1;
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end else if (st == RUN && irq_pend && !load_use) begin
            interrupt = 1'b1;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            st_nxt    = ISR;
          end else if (load_use) begin
            bubble_rst = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
          // eret returns to RUN even when paired with a mispredict; halt wins.
          if (st == ISR && !ex_halt && ex_eret)
            st_nxt = RUN;
        end
        HALTED: begin
          bubble_rst = 1'b1;
        end
        default: st_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= RUN;
      irq_pend <= 1'b0;
    end else begin
      st <= st_nxt;
      // Clearing on entry takes precedence over a coincident new request.
      if (interrupt)
        irq_pend <= 1'b0;
      else if (irq_req && int_en)
        irq_pend <= 1'b1;
    end
  end

  assign in_service = (st == ISR);
  assign halted     = (st == HALTED);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (bubble_rst && st != HALTED && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (jump_rst && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (CNT_W=4, ZERO_HAZ=0).
// Output vector order in checks: {pc_en, if_id_en, bubble_rst, jump_rst, interrupt}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_ra, id_rb, ex_desreg;
  logic       id_ra_used, id_rb_used, ex_memtoreg, ex_regwrite;
  logic       ex_mispredict, ex_halt, ex_eret, irq_req, int_en;
  logic       pc_en, if_id_en, bubble_rst, jump_rst, interrupt, in_service, halted;
  logic [3:0] stall_cnt, flush_cnt;

  int n_run = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.CNT_W(4), .ZERO_HAZ(0)) dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
    .ex_desreg(ex_desreg), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_mispredict(ex_mispredict), .ex_halt(ex_halt), .ex_eret(ex_eret),
    .irq_req(irq_req), .int_en(int_en),
    .pc_en(pc_en), .if_id_en(if_id_en), .bubble_rst(bubble_rst), .jump_rst(jump_rst),
    .interrupt(interrupt), .in_service(in_service), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_en, if_id_en, bubble_rst, jump_rst, interrupt}, {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_stall"}, {28'd0, stall_cnt}, exp_stall);
    chk({tag, "_flush"}, {28'd0, flush_cnt}, exp_flush);
`else
    chk({tag, "_stall"}, {28'd0, stall_cnt}, 0);
    chk({tag, "_flush"}, {28'd0, flush_cnt}, 0);
`endif
  endtask

  // Advance one clock; account for the bubble/flush the current cycle should count.
  task automatic tick(input bit bub, input bit jmp);
    @(negedge clk);
    if (bub && exp_stall < 15) exp_stall++;
    if (jmp && exp_flush < 15) exp_flush++;
  endtask

  task automatic clr();
    id_ra = '0; id_rb = '0; id_ra_used = 1'b0; id_rb_used = 1'b0;
    ex_desreg = '0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
    ex_mispredict = 1'b0; ex_halt = 1'b0; ex_eret = 1'b0;
    irq_req = 1'b0; int_en = 1'b0;
  endtask

  task automatic lu(input logic [4:0] r);
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_desreg = r;
    id_ra = r; id_ra_used = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    // reset forces outputs low even with a hazard present
    lu(5);
    #1 chk_out("rst_force", 5'b00000);
    tick(0, 0); exp_stall = 0; exp_flush = 0;
    rst = 1'b0; clr();
    #1 chk("rst_halted", halted, 0);
    chk("rst_insvc", in_service, 0);
    chk_out("run_idle", 5'b11000);
    chk_cnt("rst");
    tick(0, 0);

    // load-use on ra: one bubble, then normal
    lu(5);
    #1 chk_out("lu_ra", 5'b00100);
    tick(1, 0);
    clr();
    #1 chk_out("lu_after", 5'b11000);
    chk_cnt("lu");
    tick(0, 0);
    // load-use on rb
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_desreg = 5'd7;
    id_rb = 5'd7; id_rb_used = 1'b1; id_ra = 5'd7;
    #1 chk_out("lu_rb", 5'b00100);
    tick(1, 0); clr();
    // matching ra that is not read
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_desreg = 5'd9; id_ra = 5'd9;
    #1 chk_out("lu_ra_unused", 5'b11000);
    tick(0, 0); clr();
    // r0 destination never hazards
    lu(0);
    #1 chk_out("lu_r0", 5'b11000);
    tick(0, 0); clr();
    // load that does not write
    lu(5); ex_regwrite = 1'b0;
    #1 chk_out("lu_nowr", 5'b11000);
    tick(0, 0); clr();

    // mispredict wins over load-use
    lu(3); ex_mispredict = 1'b1;
    #1 chk_out("mp_lu", 5'b11010);
    tick(0, 1); clr();
    #1 chk_out("mp_after", 5'b11000);
    chk_cnt("mp");
    tick(0, 0);

    // interrupt: registered pend, delayed by load-use, survives int_en fall
    irq_req = 1'b1; int_en = 1'b1;
    #1 chk_out("irq_reg", 5'b11000);
    tick(0, 0); clr(); lu(4);
    #1 chk_out("irq_lu", 5'b00100);
    tick(1, 0); clr();
    #1 chk_out("irq_take", 5'b11001);
    chk("irq_take_insvc", in_service, 0);
    tick(0, 0);
    irq_req = 1'b1; int_en = 1'b1;
    #1 chk_out("isr_run", 5'b11000);
    chk("isr_insvc", in_service, 1);
    tick(0, 0); clr(); lu(6);
    #1 chk_out("isr_lu_nonest", 5'b00100);
    tick(1, 0); clr();
    ex_eret = 1'b1; ex_mispredict = 1'b1;
    #1 chk_out("eret_mp", 5'b11010);
    chk("eret_mp_insvc", in_service, 1);
    tick(0, 1); clr();
    #1 chk("ret_insvc", in_service, 0);
    chk_out("ret_take", 5'b11001);
    tick(0, 0); clr();
    irq_req = 1'b1; int_en = 1'b0;
    #1 chk("isr2_insvc", in_service, 1);
    tick(0, 0); clr();
    ex_eret = 1'b1;
    #1 chk_out("eret", 5'b11000);
    tick(0, 0); clr();
    #1 chk("eret_insvc", in_service, 0);
    chk_out("irq_dropped", 5'b11000);
    tick(0, 0);
    #1 chk_out("irq_dropped2", 5'b11000);
    chk_cnt("isr");
    tick(0, 0);

    // halt: flush, then frozen despite interrupts
    ex_halt = 1'b1;
    #1 chk_out("halt", 5'b00010);
    chk("halt_flag0", halted, 0);
    tick(0, 1); clr();
    irq_req = 1'b1; int_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk_out("halted_out", 5'b00100);
      chk("halted_flag", halted, 1);
      tick(0, 0);
    end
    chk_cnt("halted");
    rst = 1'b1;
    #1 chk_out("halt_rst", 5'b00000);
    tick(0, 0); exp_stall = 0; exp_flush = 0;
    rst = 1'b0; clr();
    #1 chk("unhalt", halted, 0);
    chk_out("unhalt_out", 5'b11000);
    chk_cnt("unhalt");
    tick(0, 0);

    // reset during a stall with an interrupt pending
    irq_req = 1'b1; int_en = 1'b1;
    #1 tick(0, 0);
    clr(); lu(5); rst = 1'b1;
    #1 chk_out("rst_stall", 5'b00000);
    tick(0, 0); exp_stall = 0; exp_flush = 0;
    rst = 1'b0; clr();
    #1 chk_out("rst_rel", 5'b11000);
    chk("rst_rel_insvc", in_service, 0);
    chk_cnt("rst_rel");
    tick(0, 0);

    // stall counter saturation
    lu(8);
    for (int i = 0; i < 20; i++) begin
      #1 chk_out("sat_bub", 5'b00100);
      tick(1, 0);
    end
    clr();
    #1 chk_cnt("sat");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
